// File: rtl/inst_mem_pkg.sv
// Shared types for the synchronous instruction memory: the NOP word,
// the instruction word type and the fetch response record.
package inst_mem_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  typedef logic [31:0] inst_t;

  typedef struct packed {
    inst_t       inst;
    logic [31:0] pc;
    logic        fault;
  } fetch_resp_t;

endpackage

// File: rtl/inst_mem_array.sv
// DEPTH x 32 storage with one synchronous read port and one synchronous
// write port; a same-address read and write in one cycle returns old data.
module inst_mem_array
  import inst_mem_pkg::*;
#(
  parameter int    ADDR_WIDTH = 8,
  parameter string INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [31:0]           rd_data,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [31:0]           wr_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  inst_t mem [DEPTH];
  inst_t rd_data_q;
  inst_t rd_data_d;

  // Power-up image: every word starts at zero; programs arrive on the write port.
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = NOP_INST;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // The read register only moves on an enabled read, so it holds under stall.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = mem[rd_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data_q <= NOP_INST;
    else     rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/inst_mem_sync.sv
// Fetch-stage instruction memory: decodes the PC, flags faults, registers
// one response per accepted request and counts completed fetches.
module inst_mem_sync
  import inst_mem_pkg::*;
#(
  parameter int    ADDR_WIDTH = 8,
  parameter string INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [31:0]           req_pc,
  output logic                  req_ready,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_inst,
  output logic [31:0]           resp_pc,
  output logic                  resp_fault,
  input  logic                  flush,
  input  logic                  load_en,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [31:0]           load_data,
  output logic [31:0]           fetch_count
);

  localparam int          DEPTH      = 1 << ADDR_WIDTH;
  localparam logic [32:0] BYTE_LIMIT = 33'(DEPTH) * 33'd4;

  // Handshake: a request is taken when req_valid && req_ready, with
  // req_ready = !resp_valid || resp_ready; a response completes on
  // resp_valid && resp_ready. Flush drops the held response and any request
  // accepted in the same cycle, but never blocks req_ready.

  logic                  resp_valid_q, resp_valid_d;
  logic [31:0]           resp_pc_q, resp_pc_d;
  logic                  resp_fault_q, resp_fault_d;
  logic [31:0]           fetch_count_q, fetch_count_d;

  logic                  accept;
  logic                  load_resp;
  logic                  complete;
  logic                  req_fault;
  logic [ADDR_WIDTH-1:0] word_idx;
  inst_t                 rd_data;
  fetch_resp_t           resp;

  assign req_ready = !resp_valid_q || resp_ready;
  assign accept    = req_valid && req_ready;
  assign load_resp = accept && !flush;
  assign complete  = resp_valid_q && resp_ready;

  // Any byte address at or beyond the array is a fault, so indices never alias.
  assign word_idx  = req_pc[ADDR_WIDTH+1:2];
  assign req_fault = (req_pc[1:0] != 2'b00) || ({1'b0, req_pc} >= BYTE_LIMIT);

  inst_mem_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .INIT_FILE  (INIT_FILE)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .rd_en   (load_resp && !req_fault),
    .rd_addr (word_idx),
    .rd_data (rd_data),
    .wr_en   (load_en),
    .wr_addr (load_addr),
    .wr_data (load_data)
  );

  always_comb begin
    resp_valid_d  = resp_valid_q;
    resp_pc_d     = resp_pc_q;
    resp_fault_d  = resp_fault_q;
    fetch_count_d = fetch_count_q;
    if (flush)          resp_valid_d = 1'b0;
    else if (accept)    resp_valid_d = 1'b1;
    else if (complete)  resp_valid_d = 1'b0;
    if (load_resp) begin
      resp_pc_d    = req_pc;
      resp_fault_d = req_fault;
    end
    if (complete) fetch_count_d = fetch_count_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid_q  <= 1'b0;
      resp_pc_q     <= 32'h0;
      resp_fault_q  <= 1'b0;
      fetch_count_q <= 32'h0;
    end else begin
      resp_valid_q  <= resp_valid_d;
      resp_pc_q     <= resp_pc_d;
      resp_fault_q  <= resp_fault_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // A faulted fetch never reads the array, so the stale read word is masked.
  always_comb begin
    resp.inst  = resp_fault_q ? NOP_INST : rd_data;
    resp.pc    = resp_pc_q;
    resp.fault = resp_fault_q;
  end

  assign resp_valid  = resp_valid_q;
  assign resp_inst   = resp.inst;
  assign resp_pc     = resp.pc;
  assign resp_fault  = resp.fault;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_inst_mem_sync.sv
// Randomised and directed bench for inst_mem_sync with a queue scoreboard
// fed from a word-array reference model of the memory.
`timescale 1ns/1ps
module tb_inst_mem_sync;

  localparam int AW    = 8;
  localparam int WORDS = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic [31:0]   req_pc = '0;
  logic          req_ready;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [31:0]   resp_inst;
  logic [31:0]   resp_pc;
  logic          resp_fault;
  logic          flush = 1'b0;
  logic          load_en = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [31:0]   load_data = '0;
  logic [31:0]   fetch_count;

  inst_mem_sync #(.ADDR_WIDTH(AW), .INIT_FILE("")) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_pc      (req_pc),
    .req_ready   (req_ready),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_inst   (resp_inst),
    .resp_pc     (resp_pc),
    .resp_fault  (resp_fault),
    .flush       (flush),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .fetch_count (fetch_count)
  );

  always #5 clk = ~clk;

  // Reference state: plain word array, pending responses {inst, pc, fault}.
  logic [31:0] mem_model [WORDS];
  logic [64:0] exp_q[$];
  int unsigned exp_count = 0;
  int          n_checks  = 0;
  int          n_fail    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [64:0] model_fetch(input logic [31:0] pc);
    logic        bad;
    logic [31:0] inst;
    bad  = (pc % 4 != 0) || (pc >= 4 * WORDS);
    inst = bad ? 32'h0 : mem_model[pc / 4];
    return {inst, pc, bad};
  endfunction

  // One cycle of stimulus: inputs change just after the edge, and the
  // model is updated just after the following negedge (before the edge).
  task automatic drive_cycle(input logic rv, input logic [31:0] pc, input logic rr,
                             input logic fl, input logic le, input logic [AW-1:0] la,
                             input logic [31:0] ld);
    @(posedge clk); #1;
    req_valid = rv; req_pc = pc; resp_ready = rr; flush = fl;
    load_en = le; load_addr = la; load_data = ld;
    @(negedge clk); #1;
    if (rv && req_ready && !fl) exp_q.push_back(model_fetch(pc));
    if (le) mem_model[la] = ld;
  endtask

  task automatic idle(input logic rr);
    drive_cycle(1'b0, 32'h0, rr, 1'b0, 1'b0, '0, 32'h0);
  endtask

  task automatic fetch(input logic [31:0] pc, input logic rr);
    drive_cycle(1'b1, pc, rr, 1'b0, 1'b0, '0, 32'h0);
  endtask

  // Monitor: compares presented responses with the queue head every cycle.
  always @(negedge clk) begin
    if (!rst) begin
      check("req_ready", {31'b0, req_ready}, {31'b0, (exp_q.size() == 0) || resp_ready});
      check("resp_valid", {31'b0, resp_valid}, {31'b0, exp_q.size() != 0});
      check("fetch_count", fetch_count, exp_count);
      if (exp_q.size() != 0) begin
        if (resp_valid) begin
          check("resp_inst", resp_inst, exp_q[0][64:33]);
          check("resp_pc", resp_pc, exp_q[0][32:1]);
          check("resp_fault", {31'b0, resp_fault}, {31'b0, exp_q[0][0]});
        end
        if (resp_ready) begin
          exp_count++;
          void'(exp_q.pop_front());
        end else if (flush) begin
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < WORDS; i++) mem_model[i] = 32'h0;
    #1;
    check("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
    check("rst_resp_inst", resp_inst, 32'h0);
    check("rst_fetch_count", fetch_count, 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    check("ready_after_reset", {31'b0, req_ready}, 32'h1);

    // Load then fetch word 0.
    drive_cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 8'd0, 32'hE3A0_0014);
    fetch(32'h0, 1'b1);
    idle(1'b1);
    // Back-to-back, no bubbles.
    fetch(32'h0, 1'b1); fetch(32'h4, 1'b1); fetch(32'h8, 1'b1);
    idle(1'b1); idle(1'b1);
    check("count_after_burst", fetch_count, 32'd4);
    // Stall for five cycles, then release.
    fetch(32'h0, 1'b0);
    for (int i = 0; i < 5; i++) idle(1'b0);
    idle(1'b1); idle(1'b1);
    check("count_after_stall", fetch_count, 32'd5);
    // Misaligned and out of range.
    fetch(32'h402, 1'b1); fetch(32'h400, 1'b1); fetch(32'hFFFF_FFFC, 1'b1);
    idle(1'b1);
    // Flush on the accept of PC 12, then a normal fetch of PC 16.
    drive_cycle(1'b1, 32'hC, 1'b1, 1'b1, 1'b0, '0, 32'h0);
    fetch(32'h10, 1'b1);
    idle(1'b1);
    // Flush of a stalled response.
    fetch(32'h4, 1'b0); idle(1'b0);
    drive_cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, '0, 32'h0);
    idle(1'b1);
    // Read-first collision on word 3.
    drive_cycle(1'b1, 32'hC, 1'b1, 1'b0, 1'b1, 8'd3, 32'hDEAD_BEEF);
    fetch(32'hC, 1'b1);
    idle(1'b1);

    // Reset while a response is held.
    fetch(32'h0, 1'b0);
    @(posedge clk); #1;
    req_valid = 1'b0; resp_ready = 1'b0;
    #1 check("pre_reset_valid", {31'b0, resp_valid}, 32'h1);
    rst = 1'b1;
    #1;
    check("async_rst_valid", {31'b0, resp_valid}, 32'h0);
    check("async_rst_inst", resp_inst, 32'h0);
    check("async_rst_pc", resp_pc, 32'h0);
    check("async_rst_fault", {31'b0, resp_fault}, 32'h0);
    check("async_rst_count", fetch_count, 32'h0);
    exp_q.delete();
    exp_count = 0;
    @(negedge clk); @(posedge clk); #1 rst = 1'b0;
    check("ready_after_rst2", {31'b0, req_ready}, 32'h1);
    fetch(32'h0, 1'b1); fetch(32'hC, 1'b1);
    idle(1'b1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] pc;
      int          kind;
      kind = $urandom_range(0, 9);
      if (kind < 7)      pc = 32'($urandom_range(0, WORDS - 1)) * 4;
      else if (kind < 8) pc = (32'($urandom_range(0, WORDS - 1)) * 4) | 32'($urandom_range(1, 3));
      else               pc = 32'h400 + (32'($urandom_range(0, 4096)) * 4);
      drive_cycle(1'($urandom_range(0, 3) != 0), pc, 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 11) == 0), 1'($urandom_range(0, 3) == 0),
                  8'($urandom_range(0, WORDS - 1)), $urandom);
    end
    idle(1'b1); idle(1'b1); idle(1'b1);
    check("queue_drained", exp_q.size(), 32'h0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
